// File: rtl/st_video_pkg.sv
// Shared video timing package: display modes and line/frame boundary constants,
// used by syncgen and the vertical DE generator.
package st_video_pkg;

    localparam int unsigned HCNT_W = 9;
    localparam int unsigned VCNT_W = 9;

    // Line length (en8 cycles) and frame length (lines) per mode
    localparam int unsigned HT_PAL  = 512;
    localparam int unsigned VT_PAL  = 313;
    localparam int unsigned HT_NTSC = 508;
    localparam int unsigned VT_NTSC = 263;
    localparam int unsigned HT_MONO = 224;
    localparam int unsigned VT_MONO = 501;

    // Horizontal sync sits at the end of the line
    localparam int unsigned HSYNC_LEN_COLOUR = 40;
    localparam int unsigned HSYNC_LEN_MONO   = 16;

    localparam int unsigned HDE_FIRST_COLOUR = 56;
    localparam int unsigned HDE_LAST_COLOUR  = 375;
    localparam int unsigned HDE_FIRST_MONO   = 4;
    localparam int unsigned HDE_LAST_MONO    = 163;

    // Colour blanking covers the last HBLANK_LEAD and first HBLANK_TAIL cycles
    localparam int unsigned HBLANK_LEAD = 64;
    localparam int unsigned HBLANK_TAIL = 16;

    localparam int unsigned VSYNC_LINES_COLOUR = 3;
    localparam int unsigned VSYNC_LINES_MONO   = 2;

    typedef enum logic [1:0] {
        MODE_PAL  = 2'd0,
        MODE_NTSC = 2'd1,
        MODE_MONO = 2'd2
    } video_mode_e;

    typedef struct packed {
        logic [HCNT_W-1:0] hs_first;
        logic [HCNT_W-1:0] hde_first;
        logic [HCNT_W-1:0] hde_last;
        logic [HCNT_W-1:0] hb_first;
        logic [HCNT_W-1:0] hb_tail;
        logic              hb_en;
        logic [VCNT_W-1:0] vs_last;
    } decode_limits_t;

    function automatic int unsigned line_len(input video_mode_e mode);
        int unsigned ht;
        case (mode)
            MODE_NTSC: ht = HT_NTSC;
            MODE_MONO: ht = HT_MONO;
            default:   ht = HT_PAL;
        endcase
        return ht;
    endfunction

    function automatic int unsigned frame_len(input video_mode_e mode);
        int unsigned vt;
        case (mode)
            MODE_NTSC: vt = VT_NTSC;
            MODE_MONO: vt = VT_MONO;
            default:   vt = VT_PAL;
        endcase
        return vt;
    endfunction

    function automatic logic [HCNT_W-1:0] line_last(input video_mode_e mode);
        return HCNT_W'(line_len(mode) - 1);
    endfunction

    function automatic logic [VCNT_W-1:0] frame_last(input video_mode_e mode);
        return VCNT_W'(frame_len(mode) - 1);
    endfunction

    // Output decode boundaries for a given mode
    function automatic decode_limits_t decode_limits(input video_mode_e mode);
        decode_limits_t lim;
        int unsigned    ht;
        logic           mono;
        ht   = line_len(mode);
        mono = (mode == MODE_MONO);
        lim.hs_first  = HCNT_W'(ht - (mono ? HSYNC_LEN_MONO : HSYNC_LEN_COLOUR));
        lim.hde_first = HCNT_W'(mono ? HDE_FIRST_MONO : HDE_FIRST_COLOUR);
        lim.hde_last  = HCNT_W'(mono ? HDE_LAST_MONO : HDE_LAST_COLOUR);
        lim.hb_first  = HCNT_W'(ht - HBLANK_LEAD);
        lim.hb_tail   = HCNT_W'(HBLANK_TAIL);
        lim.hb_en     = !mono;
        lim.vs_last   = VCNT_W'((mono ? VSYNC_LINES_MONO : VSYNC_LINES_COLOUR) - 1);
        return lim;
    endfunction

endpackage

// File: rtl/syncgen.sv
// Horizontal/vertical sync generator for PAL, NTSC and mono timings.
// Optional SYNCGEN_NTSC_EN: when defined, cntsc selects NTSC timing; otherwise colour is always PAL.
module syncgen
    import st_video_pkg::*;
(
    input  logic              clk,
    input  logic              porb,
    input  logic              en8,
    input  logic              mde1,
    input  logic              cpal,
    input  logic              cntsc,
    output logic              hsync,
    output logic              vsync,
    output logic              hde,
    output logic              hblank,
    output logic [VCNT_W-1:0] vcnt
);

    logic [HCNT_W-1:0] hcnt_q;
    logic [HCNT_W-1:0] hcnt_d;
    logic [VCNT_W-1:0] vcnt_d;
    video_mode_e       mode_q;
    video_mode_e       mode_d;
    video_mode_e       mode_sel;
    decode_limits_t    lim_d;
    logic              hsync_d;
    logic              vsync_d;
    logic              hde_d;
    logic              hblank_d;
    logic              unused_mode_pins;

    // PAL is the fallback whenever no other mode is selected, so cpal never steers
`ifdef SYNCGEN_NTSC_EN
    assign mode_sel         = mde1 ? MODE_MONO : (cntsc ? MODE_NTSC : MODE_PAL);
    assign unused_mode_pins = cpal;
`else
    assign mode_sel         = mde1 ? MODE_MONO : MODE_PAL;
    assign unused_mode_pins = cpal ^ cntsc;
`endif

    // Counter advance; mode is sampled only at the line wrap. The >= compares
    // keep a counter left beyond a shorter new limit from running away.
    always_comb begin
        hcnt_d = hcnt_q + HCNT_W'(1);
        vcnt_d = vcnt;
        mode_d = mode_q;
        if (hcnt_q >= line_last(mode_q)) begin
            hcnt_d = '0;
            mode_d = mode_sel;
            vcnt_d = (vcnt >= frame_last(mode_q)) ? '0 : vcnt + VCNT_W'(1);
        end
    end

    // Outputs decode the counter values they are registered alongside
    always_comb begin
        lim_d    = decode_limits(mode_d);
        hsync_d  = (hcnt_d >= lim_d.hs_first);
        hde_d    = (hcnt_d >= lim_d.hde_first) && (hcnt_d <= lim_d.hde_last);
        hblank_d = lim_d.hb_en && ((hcnt_d >= lim_d.hb_first) || (hcnt_d < lim_d.hb_tail));
        vsync_d  = (vcnt_d <= lim_d.vs_last);
    end

    always_ff @(posedge clk or negedge porb) begin
        if (!porb) begin
            hcnt_q <= '0;
            vcnt   <= '0;
            mode_q <= MODE_PAL;
            hsync  <= 1'b0;
            vsync  <= 1'b0;
            hde    <= 1'b0;
            hblank <= 1'b0;
        end else if (en8) begin
            hcnt_q <= hcnt_d;
            vcnt   <= vcnt_d;
            mode_q <= mode_d;
            hsync  <= hsync_d;
            vsync  <= vsync_d;
            hde    <= hde_d;
            hblank <= hblank_d;
        end
    end

endmodule

// File: tb/tb_syncgen.sv
// Self-checking bench for syncgen: boundary vector table, timing measurements,
// multi-cycle corner sequences and a randomized run against a reference model.
module tb_syncgen;

    logic       clk   = 1'b0;
    logic       porb  = 1'b0;
    logic       en8   = 1'b0;
    logic       mde1  = 1'b0;
    logic       cpal  = 1'b0;
    logic       cntsc = 1'b0;
    logic       hsync;
    logic       vsync;
    logic       hde;
    logic       hblank;
    logic [8:0] vcnt;

`ifdef SYNCGEN_NTSC_EN
    localparam bit NTSC_ON = 1'b1;
`else
    localparam bit NTSC_ON = 1'b0;
`endif

    syncgen dut (
        .clk   (clk),
        .porb  (porb),
        .en8   (en8),
        .mde1  (mde1),
        .cpal  (cpal),
        .cntsc (cntsc),
        .hsync (hsync),
        .vsync (vsync),
        .hde   (hde),
        .hblank(hblank),
        .vcnt  (vcnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      name;
        bit         m;
        bit         n;
        int         ticks;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [12:0] obs();
        return {hsync, vsync, hde, hblank, vcnt};
    endfunction

    function automatic vec_t mk(string nm, bit m, bit n, int t,
                                bit hs, bit vs, bit de, bit hb, int v);
        vec_t r;
        r.name  = nm;
        r.m     = m;
        r.n     = n;
        r.ticks = t;
        r.exp   = {hs, vs, de, hb, 9'(v)};
        return r;
    endfunction

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {hs,vs,de,hb,vcnt}=%b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input bit e);
        en8 = e;
        @(negedge clk);
    endtask

    task automatic do_reset();
        porb = 1'b0;
        en8  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        porb = 1'b1;
    endtask

    task automatic count_line(output int n);
        logic [8:0] v0;
        v0 = vcnt;
        n  = 0;
        while (vcnt === v0 && n < 2000) begin
            step(1'b1);
            n++;
        end
    endtask

    // Measures the span between the 2nd and 3rd hsync rising edges in clk cycles
    task automatic measure(input int per, output int period, output int hs_hi,
                           output int de_hi, output int hb_hi, output bit stable_ok);
        int          cyc;
        int          rises;
        bit          e;
        logic [12:0] prev;
        cyc = 0; rises = 0; period = 0; hs_hi = 0; de_hi = 0; hb_hi = 0; stable_ok = 1'b1;
        while (rises < 3 && cyc < 4000 * per) begin
            e    = ((cyc % per) == 0);
            prev = obs();
            step(e);
            cyc++;
            if (!e && obs() !== prev) stable_ok = 1'b0;
            if (hsync && !prev[12]) rises++;
            if (rises == 2) begin
                period++;
                hs_hi += int'(hsync);
                de_hi += int'(hde);
                hb_hi += int'(hblank);
            end
        end
        if (rises < 3) begin
            period = -1;
        end
    endtask

    // Reference model state: line position, line number, active mode (0 PAL, 1 NTSC, 2 MONO)
    function automatic int m_line_len(int m);
        return (m == 1) ? 508 : (m == 2) ? 224 : 512;
    endfunction

    function automatic int m_frame_len(int m);
        return (m == 1) ? 263 : (m == 2) ? 501 : 313;
    endfunction

    function automatic logic [12:0] model_out(int m, int h, int v);
        bit mono;
        int len;
        bit hs, vs, de, hb;
        mono = (m == 2);
        len  = m_line_len(m);
        hs   = (h >= len - (mono ? 16 : 40));
        de   = mono ? (h >= 4 && h <= 163) : (h >= 56 && h <= 375);
        hb   = !mono && (h >= len - 64 || h < 16);
        vs   = (v < (mono ? 2 : 3));
        return {hs, vs, de, hb, 9'(v)};
    endfunction

    function automatic int resolve(bit m, bit n);
        return m ? 2 : ((NTSC_ON && n) ? 1 : 0);
    endfunction

    initial begin
        int          period, hs_hi, de_hi, hb_hi, n;
        bit          stable_ok;
        int          mh, mv, mm;
        bit          mz, e;
        logic [12:0] expv;

        // Boundary vectors: ticks counted from reset release; first line is always PAL
        vecs.push_back(mk("pal_t0",          0, 0,    0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("pal_t1",          0, 0,    1, 0, 1, 0, 1, 0));
        vecs.push_back(mk("pal_t15",         0, 0,   15, 0, 1, 0, 1, 0));
        vecs.push_back(mk("pal_t16",         0, 0,   16, 0, 1, 0, 0, 0));
        vecs.push_back(mk("pal_t55",         0, 0,   55, 0, 1, 0, 0, 0));
        vecs.push_back(mk("pal_hde_first",   0, 0,   56, 0, 1, 1, 0, 0));
        vecs.push_back(mk("pal_hde_last",    0, 0,  375, 0, 1, 1, 0, 0));
        vecs.push_back(mk("pal_t376",        0, 0,  376, 0, 1, 0, 0, 0));
        vecs.push_back(mk("pal_t447",        0, 0,  447, 0, 1, 0, 0, 0));
        vecs.push_back(mk("pal_hb_first",    0, 0,  448, 0, 1, 0, 1, 0));
        vecs.push_back(mk("pal_t471",        0, 0,  471, 0, 1, 0, 1, 0));
        vecs.push_back(mk("pal_hs_first",    0, 0,  472, 1, 1, 0, 1, 0));
        vecs.push_back(mk("pal_t511",        0, 0,  511, 1, 1, 0, 1, 0));
        vecs.push_back(mk("pal_wrap",        0, 0,  512, 0, 1, 0, 1, 1));
        vecs.push_back(mk("pal_vs_last",     0, 0, 1535, 1, 1, 0, 1, 2));
        vecs.push_back(mk("pal_vs_end",      0, 0, 1536, 0, 0, 0, 1, 3));
        vecs.push_back(mk("mono_first",      1, 0,  512, 0, 1, 0, 0, 1));
        vecs.push_back(mk("mono_t3",         1, 0,  515, 0, 1, 0, 0, 1));
        vecs.push_back(mk("mono_hde_first",  1, 0,  516, 0, 1, 1, 0, 1));
        vecs.push_back(mk("mono_hde_last",   1, 0,  675, 0, 1, 1, 0, 1));
        vecs.push_back(mk("mono_t676",       1, 0,  676, 0, 1, 0, 0, 1));
        vecs.push_back(mk("mono_t719",       1, 0,  719, 0, 1, 0, 0, 1));
        vecs.push_back(mk("mono_hs_first",   1, 0,  720, 1, 1, 0, 0, 1));
        vecs.push_back(mk("mono_t735",       1, 0,  735, 1, 1, 0, 0, 1));
        vecs.push_back(mk("mono_vs_end",     1, 0,  736, 0, 0, 0, 0, 2));
        vecs.push_back(mk("mono_over_ntsc",  1, 1,  720, 1, 1, 0, 0, 1));
        vecs.push_back(mk("ntsc_t955",       0, 1,  955, 0, 1, 0, 0, 1));
        vecs.push_back(mk("ntsc_t956",       0, 1,  956, 0, 1, 0, NTSC_ON, 1));
        vecs.push_back(mk("ntsc_t979",       0, 1,  979, 0, 1, 0, 1, 1));
        vecs.push_back(mk("ntsc_t980",       0, 1,  980, NTSC_ON, 1, 0, 1, 1));
        vecs.push_back(mk("ntsc_t1019",      0, 1, 1019, 1, 1, 0, 1, 1));
        vecs.push_back(mk("ntsc_t1020",      0, 1, 1020, !NTSC_ON, 1, 0, 1, NTSC_ON ? 2 : 1));

        @(negedge clk);
        check("reset_state", obs(), 13'd0);

        foreach (vecs[i]) begin
            mde1  = vecs[i].m;
            cntsc = vecs[i].n;
            do_reset();
            for (int t = 0; t < vecs[i].ticks; t++) step(1'b1);
            check(vecs[i].name, obs(), vecs[i].exp);
        end

        // Line-level timing measurements
        mde1 = 1'b0; cntsc = 1'b0;
        do_reset();
        measure(1, period, hs_hi, de_hi, hb_hi, stable_ok);
        check_int("pal_period", period, 512);
        check_int("pal_hs_high", hs_hi, 40);
        check_int("pal_hde_high", de_hi, 320);
        check_int("pal_hblank_high", hb_hi, 80);

        do_reset();
        measure(4, period, hs_hi, de_hi, hb_hi, stable_ok);
        check_int("en4_period", period, 2048);
        check_int("en4_hs_high", hs_hi, 160);
        check_int("en4_hde_high", de_hi, 1280);
        check_int("en4_stable", int'(stable_ok), 1);

        mde1 = 1'b1;
        do_reset();
        measure(1, period, hs_hi, de_hi, hb_hi, stable_ok);
        check_int("mono_period", period, 224);
        check_int("mono_hs_high", hs_hi, 16);
        check_int("mono_hde_high", de_hi, 160);
        check_int("mono_hblank_high", hb_hi, 0);

        mde1 = 1'b0; cntsc = 1'b1;
        do_reset();
        measure(1, period, hs_hi, de_hi, hb_hi, stable_ok);
        check_int("ntsc_period", period, NTSC_ON ? 508 : 512);
        check_int("ntsc_hs_high", hs_hi, 40);

        // Mode switch mid-line: current line finishes at the old length
        cntsc = 1'b0; mde1 = 1'b0;
        do_reset();
        for (int t = 0; t < 612; t++) step(1'b1);
        check("switch_pre", obs(), {1'b0, 1'b1, 1'b1, 1'b0, 9'd1});
        mde1 = 1'b1;
        count_line(n);
        check_int("switch_rest_of_line", n, 412);
        count_line(n);
        check_int("switch_next_line", n, 224);

        // A select pulse that ends before the wrap is never seen
        mde1 = 1'b0;
        do_reset();
        for (int t = 0; t < 100; t++) step(1'b1);
        mde1 = 1'b1;
        for (int t = 0; t < 100; t++) step(1'b1);
        mde1 = 1'b0;
        count_line(n);
        check_int("glitch_rest_of_line", n, 312);
        count_line(n);
        check_int("glitch_next_line", n, 512);

        // Reset asserted mid-line clears outputs without waiting for a clock
        do_reset();
        for (int t = 0; t < 300; t++) step(1'b1);
        check("midline_pre", obs(), {1'b0, 1'b1, 1'b1, 1'b0, 9'd0});
        #2 porb = 1'b0;
        #1 check("async_reset", obs(), 13'd0);
        @(negedge clk);
        step(1'b1);
        step(1'b1);
        check("held_in_reset", obs(), 13'd0);
        porb = 1'b1;
        n = 0;
        while (!hsync && n < 1000) begin
            step(1'b1);
            n++;
        end
        check_int("first_hsync_after_reset", n, 472);

        // Randomized run against the reference model
        mde1  = 1'($urandom);
        cntsc = 1'($urandom);
        do_reset();
        mh = 0; mv = 0; mm = 0; mz = 1'b1;
        for (int i = 0; i < 15000; i++) begin
            expv = mz ? 13'd0 : model_out(mm, mh, mv);
            check("random", obs(), expv);
            if ($urandom_range(0, 299) == 0) mde1  = 1'($urandom);
            if ($urandom_range(0, 299) == 0) cntsc = 1'($urandom);
            if ($urandom_range(0, 99) == 0)  cpal  = 1'($urandom);
            e = ($urandom_range(0, 2) != 0);
            if (e) begin
                mz = 1'b0;
                if (mh >= m_line_len(mm) - 1) begin
                    mh = 0;
                    mv = (mv >= m_frame_len(mm) - 1) ? 0 : mv + 1;
                    mm = resolve(mde1, cntsc);
                end else begin
                    mh++;
                end
            end
            step(e);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/syncgen.md
SYNCGEN -- requirements
Module: syncgen

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-002 SHALL have port porb, input, 1, power-on reset; asynchronous, active-low.
REQ-003 SHALL have port en8, input, 1, 8 MHz cycle enable; counters and outputs advance only when en8=1.
REQ-004 SHALL have port mde1, input, 1, monochrome (high-res) mode select.
REQ-005 SHALL have port cpal, input, 1, 50 Hz colour mode select.
REQ-006 SHALL have port cntsc, input, 1, 60 Hz colour mode select.
REQ-007 SHALL have port hsync, output, 1, horizontal sync, active-high, registered.
REQ-008 SHALL have port vsync, output, 1, vertical sync, active-high, registered.
REQ-009 SHALL have port hde, output, 1, horizontal display enable, registered.
REQ-010 SHALL have port hblank, output, 1, horizontal blank, registered.
REQ-011 SHALL have port vcnt, output, 9, current line number (debug/observation).

Function
REQ-012 SHALL resolve mode with priority: mde1 -> MONO; else cntsc (when enabled, REQ-025) -> NTSC; else PAL (also when no select is asserted).
REQ-013 SHALL use line length HT and frame length VT: PAL 512/313, NTSC 508/263, MONO 224/501 en8 cycles/lines.
REQ-014 SHALL count hcnt 0..HT-1 on en8, wrap to 0 after HT-1; vcnt increments at hcnt wrap, wraps to 0 after VT-1.
REQ-015 SHALL latch the resolved mode into an internal mode register only at hcnt wrap; mode inputs are ignored mid-line.
REQ-016 SHALL, if after a mode change hcnt>=HT-1 or vcnt>=VT-1, wrap that counter to 0 at its next advance (no runaway count).
REQ-017 SHALL assert hsync for hcnt in [HT-40, HT-1] in colour modes and [HT-16, HT-1] in MONO.
REQ-018 SHALL assert hde for hcnt in [56, 375] in colour modes (320 cycles) and [4, 163] in MONO (160 cycles).
REQ-019 SHALL assert hblank for hcnt >= HT-64 or hcnt < 16 in colour modes; hblank stays 0 in MONO.
REQ-020 SHALL assert vsync for vcnt in [0, 2] in colour modes and [0, 1] in MONO.
REQ-021 SHALL register all outputs at the same en8 edge that updates the counters, so each output is the decode of the counter values it accompanies (zero skew between hsync, hde, hblank, vsync, vcnt).
REQ-022 SHALL hold all state and outputs unchanged while en8=0.

Reset
REQ-023 SHALL, while porb=0, force hcnt=0, vcnt=0, mode=PAL, and hsync=vsync=hde=hblank=0 asynchronously.
REQ-024 SHALL, on the first en8 cycle after porb rises, resume counting from hcnt=0/vcnt=0 with outputs taking the decode of the new counter values; reset mid-line truncates the line with no partial pulse held.

Configuration
REQ-025 SHALL honour macro SYNCGEN_NTSC_EN: defined -> cntsc selects NTSC timing per REQ-012/013; undefined -> cntsc port present but ignored, colour always PAL.

Structure
REQ-026 SHALL place mode enum (PAL/NTSC/MONO) and all HT/VT, sync, hde, and hblank boundary constants in shared package st_video_pkg, shared with the vertical DE generator.
REQ-027 SHALL be a single module with no sub-module; the limit lookup is a package function.

Verification
REQ-028 PAL, en8 every clk -> hsync period 512 cycles, high 40; vsync high 3 lines; frame 160256 cycles; hde high 320 cycles per line.
REQ-029 NTSC with SYNCGEN_NTSC_EN -> line 508, frame 133604 cycles; same run without the macro -> line 512, frame 160256.
REQ-030 MONO -> line 224, hsync high 16, hde 160 cycles at hcnt 4..163, hblank never 1, vsync 2 lines, frame 112224 cycles.
REQ-031 Switch mde1 0->1 at PAL hcnt=100, vcnt=400-equivalent (vcnt=310) -> line 310 completes at 512; next line 224; vcnt 400 case from MONO->PAL wraps vcnt to 0 at next line end.
REQ-032 Assert porb=0 mid-line at hcnt=300 -> all outputs 0 immediately; after release, hsync first rises at hcnt 472 (PAL).
REQ-033 en8 toggling 1-in-4 -> all periods scale ×4; outputs stable across disabled cycles.
